// File: rtl/clock_timebase_ctrl.sv
// Mode sequencer and BCD sec/min/hr counter chain for the lab digital clock.
// Every rollover is produced synchronously in the CP domain; a 3-state FSM handles time setting.
module clock_timebase_ctrl #(
    parameter int HOUR_MOD = 24
) (
    input  logic       CP,
    input  logic       CR_n,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic [1:0] mode,
    output logic       blink,
    output logic       hour_pulse
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_t;

    localparam logic [3:0] HR_MAX_HI = 4'((HOUR_MOD - 1) / 10);
    localparam logic [3:0] HR_MAX_LO = 4'((HOUR_MOD - 1) % 10);

    mode_t      state_q, state_d;
    logic [3:0] sec_lo_d, sec_hi_d, min_lo_d, min_hi_d, hr_lo_d, hr_hi_d;
    logic       blink_d, hour_pulse_d;
    logic       sec_wrap, min_wrap;

    function automatic logic [7:0] inc_mod60(input logic [3:0] hi, input logic [3:0] lo);
        if (lo != 4'd9) return {hi, lo + 4'd1};
        if (hi != 4'd5) return {hi + 4'd1, 4'd0};
        return 8'h00;
    endfunction

    // Hours wrap on the combined two-digit value, so 19->20 carries but 23->00 wraps.
    function automatic logic [7:0] inc_hour(input logic [3:0] hi, input logic [3:0] lo);
        if (hi == HR_MAX_HI && lo == HR_MAX_LO) return 8'h00;
        if (lo == 4'd9) return {hi + 4'd1, 4'd0};
        return {hi, lo + 4'd1};
    endfunction

    assign sec_wrap = (sec_hi == 4'd5) && (sec_lo == 4'd9);
    assign min_wrap = (min_hi == 4'd5) && (min_lo == 4'd9);
    assign mode     = state_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d      = state_q;
        sec_lo_d     = sec_lo;
        sec_hi_d     = sec_hi;
        min_lo_d     = min_lo;
        min_hi_d     = min_hi;
        hr_lo_d      = hr_lo;
        hr_hi_d      = hr_hi;
        blink_d      = blink;
        hour_pulse_d = 1'b0;

        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                if (tick) begin
                    {sec_hi_d, sec_lo_d} = inc_mod60(sec_hi, sec_lo);
                    if (sec_wrap) begin
                        {min_hi_d, min_lo_d} = inc_mod60(min_hi, min_lo);
                        if (min_wrap) begin
                            {hr_hi_d, hr_lo_d} = inc_hour(hr_hi, hr_lo);
                            hour_pulse_d       = 1'b1;
                        end
                    end
                end
                if (mode_btn) state_d = SET_HR;
            end
            SET_HR: begin
                if (tick) blink_d = ~blink;
                if (mode_btn) state_d = SET_MIN;
                else if (inc_btn) {hr_hi_d, hr_lo_d} = inc_hour(hr_hi, hr_lo);
            end
            SET_MIN: begin
                if (tick) blink_d = ~blink;
                if (mode_btn) begin
                    state_d  = RUN;
                    blink_d  = 1'b0;
                    sec_lo_d = 4'd0;
                    sec_hi_d = 4'd0;
                end else if (inc_btn) begin
                    {min_hi_d, min_lo_d} = inc_mod60(min_hi, min_lo);
                end
            end
            default: begin
                // Upset into the unused encoding: recover to RUN, time untouched.
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CP or negedge CR_n) begin
        if (!CR_n) begin
            state_q    <= RUN;
            sec_lo     <= 4'd0;
            sec_hi     <= 4'd0;
            min_lo     <= 4'd0;
            min_hi     <= 4'd0;
            hr_lo      <= 4'd0;
            hr_hi      <= 4'd0;
            blink      <= 1'b0;
            hour_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            state_q    <= state_d;
            sec_lo     <= sec_lo_d;
            sec_hi     <= sec_hi_d;
            min_lo     <= min_lo_d;
            min_hi     <= min_hi_d;
            hr_lo      <= hr_lo_d;
            hr_hi      <= hr_hi_d;
            blink      <= blink_d;
            hour_pulse <= hour_pulse_d;
        end
    end

endmodule

// File: tb/tb_clock_timebase_ctrl.sv
// Directed bench for clock_timebase_ctrl: a HOUR_MOD=24 instance (a) and a HOUR_MOD=12 instance (b).
module tb_clock_timebase_ctrl;

    logic CP = 1'b0;
    logic CR_n;
    logic tick_a, mode_a, inc_a;
    logic tick_b, mode_b, inc_b;

    logic [3:0] a_sec_lo, a_sec_hi, a_min_lo, a_min_hi, a_hr_lo, a_hr_hi;
    logic [3:0] b_sec_lo, b_sec_hi, b_min_lo, b_min_hi, b_hr_lo, b_hr_hi;
    logic [1:0] a_mode, b_mode;
    logic       a_blink, b_blink, a_hp, b_hp;

    logic [23:0] time_a, time_b;
    assign time_a = {a_hr_hi, a_hr_lo, a_min_hi, a_min_lo, a_sec_hi, a_sec_lo};
    assign time_b = {b_hr_hi, b_hr_lo, b_min_hi, b_min_lo, b_sec_hi, b_sec_lo};

    int tests  = 0;
    int errors = 0;
    int hp_cnt_a = 0;
    int hp_cnt_b = 0;

    always #5 CP = ~CP;

    clock_timebase_ctrl #(.HOUR_MOD(24)) dut_a (
        .CP(CP), .CR_n(CR_n), .tick(tick_a), .mode_btn(mode_a), .inc_btn(inc_a),
        .sec_lo(a_sec_lo), .sec_hi(a_sec_hi), .min_lo(a_min_lo), .min_hi(a_min_hi),
        .hr_lo(a_hr_lo), .hr_hi(a_hr_hi), .mode(a_mode), .blink(a_blink), .hour_pulse(a_hp)
    );

    clock_timebase_ctrl #(.HOUR_MOD(12)) dut_b (
        .CP(CP), .CR_n(CR_n), .tick(tick_b), .mode_btn(mode_b), .inc_btn(inc_b),
        .sec_lo(b_sec_lo), .sec_hi(b_sec_hi), .min_lo(b_min_lo), .min_hi(b_min_hi),
        .hr_lo(b_hr_lo), .hr_hi(b_hr_hi), .mode(b_mode), .blink(b_blink), .hour_pulse(b_hp)
    );

    // Count cycles with hour_pulse high, sampled just after each rising edge.
    always @(posedge CP) begin
        #1;
        if (a_hp) hp_cnt_a++;
        if (b_hp) hp_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle pulse on the selected instance's inputs (sel 0 = a, 1 = b).
    task automatic drive(input bit sel, input bit t, input bit m, input bit i);
        @(negedge CP);
        if (!sel) {tick_a, mode_a, inc_a} = {t, m, i};
        else      {tick_b, mode_b, inc_b} = {t, m, i};
        @(negedge CP);
        {tick_a, mode_a, inc_a} = 3'b000;
        {tick_b, mode_b, inc_b} = 3'b000;
    endtask

    task automatic ticks(input bit sel, input int n);
        for (int k = 0; k < n; k++) drive(sel, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input bit sel, input int n);
        for (int k = 0; k < n; k++) drive(sel, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int hp_snap;
        {tick_a, mode_a, inc_a} = 3'b000;
        {tick_b, mode_b, inc_b} = 3'b000;
        CR_n = 1'b0;
        repeat (2) @(negedge CP);
        CR_n = 1'b1;
        @(negedge CP);

        check("reset_time_a", 32'(time_a), 32'h0);
        check("reset_time_b", 32'(time_b), 32'h0);
        check("reset_mode", 32'(a_mode), 32'h0);
        check("reset_blink", 32'(a_blink), 32'h0);
        check("reset_hp", 32'(a_hp), 32'h0);

        // 60 ticks roll seconds into minutes without any chime.
        ticks(1'b0, 60);
        check("run_60s", 32'(time_a), 32'h000100);
        check("run_60s_no_hp", 32'(hp_cnt_a), 32'd0);

        // Advance to 00:59:59, then one tick crosses the hour.
        ticks(1'b0, 3539);
        check("run_005959", 32'(time_a), 32'h005959);
        check("no_hp_before_hour", 32'(hp_cnt_a), 32'd0);
        ticks(1'b0, 1);
        check("run_010000", 32'(time_a), 32'h010000);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("hp_one_cycle", 32'(hp_cnt_a), 32'd1);
        check("hp_low_after", 32'(a_hp), 32'h0);

        // Asynchronous reset between edges clears everything at once.
        @(negedge CP);
        tick_a = 1'b1;
        #2 CR_n = 1'b0;
        #1;
        check("async_rst_time", 32'(time_a), 32'h0);
        check("async_rst_mode", 32'(a_mode), 32'h0);
        tick_a = 1'b0;
        @(negedge CP);
        CR_n = 1'b1;

        // mode_btn together with tick in RUN: tick applied, then SET_HR.
        ticks(1'b0, 5);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check("mode_tick_time", 32'(time_a), 32'h000006);
        check("enter_set_hr", 32'(a_mode), 32'h1);
        check("enter_blink0", 32'(a_blink), 32'h0);
        ticks(1'b0, 1);
        check("set_hr_frozen", 32'(time_a), 32'h000006);
        check("blink_tog1", 32'(a_blink), 32'h1);
        ticks(1'b0, 1);
        check("blink_tog0", 32'(a_blink), 32'h0);

        hp_snap = hp_cnt_a;
        incs(1'b0, 25);
        check("hr_25inc", 32'(time_a), 32'h010006);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("tick_inc_hr", 32'(time_a), 32'h020006);
        check("tick_inc_blink", 32'(a_blink), 32'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("mode_inc_mode", 32'(a_mode), 32'h2);
        check("mode_inc_hr", 32'(time_a), 32'h020006);

        incs(1'b0, 61);
        check("min_61inc", 32'(time_a), 32'h020106);
        check("set_no_hp", 32'(hp_cnt_a), 32'(hp_snap));
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("exit_run_mode", 32'(a_mode), 32'h0);
        check("exit_sec_clear", 32'(time_a), 32'h020100);
        check("exit_blink0", 32'(a_blink), 32'h0);

        // Day wrap, HOUR_MOD=24: preload 23:59 then 59 ticks.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        incs(1'b0, 21);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        incs(1'b0, 58);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1'b0, 59);
        check("a_235959", 32'(time_a), 32'h235959);
        hp_snap = hp_cnt_a;
        ticks(1'b0, 1);
        check("a_day_wrap", 32'(time_a), 32'h000000);
        check("a_wrap_hp", 32'(hp_cnt_a), 32'(hp_snap + 1));

        // Day wrap, HOUR_MOD=12.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        incs(1'b1, 11);
        check("b_hr11", 32'(time_b), 32'h110000);
        incs(1'b1, 1);
        check("b_hr_wrap", 32'(time_b), 32'h000000);
        incs(1'b1, 11);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        incs(1'b1, 59);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("b_run", 32'(b_mode), 32'h0);
        ticks(1'b1, 59);
        check("b_115959", 32'(time_b), 32'h115959);
        hp_snap = hp_cnt_b;
        ticks(1'b1, 1);
        check("b_day_wrap", 32'(time_b), 32'h000000);
        check("b_wrap_hp", 32'(hp_cnt_b), 32'(hp_snap + 1));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
